// File: rtl/gpu_pkg.sv
// gpu_pkg: shared register map, irq bit positions, fill FSM states and VRAM width
package gpu_pkg;
    localparam int VRAM_ADDR_WIDTH = 13;
    localparam logic [3:0] REG_ADDR_LO     = 4'd0;
    localparam logic [3:0] REG_ADDR_HI     = 4'd1;
    localparam logic [3:0] REG_DATA        = 4'd2;
    localparam logic [3:0] REG_INCR        = 4'd3;
    localparam logic [3:0] REG_IRQ_EN      = 4'd4;
    localparam logic [3:0] REG_IRQ_ACK     = 4'd5;
    localparam logic [3:0] REG_FILL_VAL    = 4'd6;
    localparam logic [3:0] REG_FILL_CNT_LO = 4'd7;
    localparam logic [3:0] REG_FILL_CNT_HI = 4'd8;
    localparam logic [3:0] REG_FILL_GO     = 4'd9;
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_FILL   = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} fill_state_t;
endpackage

// File: rtl/bus_strobe_sync.sv
// bus_strobe_sync: synchronises the async CPU strobe and emits a one-cycle pulse on its rising edge
module bus_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], strobe};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign pulse = sync[SYNC_STAGES-1] & ~prev;
endmodule

// File: rtl/gpu_bus_interface.sv
// gpu_bus_interface: CPU register bus responder driving the VRAM write port, fill engine and irq
module gpu_bus_interface
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
    parameter int VBLANK_LINE = 480,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK100MHz,
    input  logic                  rst,
    input  logic [7:0]            data,
    input  logic [3:0]            addr,
    input  logic                  rw,
    input  logic                  cs_clock,
    input  logic [8:0]            scanline,
    output logic                  vram_we,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [7:0]            vram_wdata,
    output logic                  busy,
    output logic                  irq
);
    fill_state_t state, state_next;
    logic strobe, acc_valid, acc_rw, wr, vblank_hit, vblank_prev;
    logic [3:0] acc_addr;
    logic [7:0] acc_data, incr, fill_val;
    logic [1:0] irq_en, pending, set, ack;
    logic [13:0] fill_cnt;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_step;

    bus_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(CLK100MHz), .rst(rst), .strobe(cs_clock), .pulse(strobe)
    );

    always_comb begin
        wr = acc_valid & ~acc_rw;
        vblank_hit = scanline == 9'(VBLANK_LINE);
        addr_step = addr_reg + ADDR_WIDTH'(incr);
        ack = (wr && acc_addr == REG_IRQ_ACK) ? acc_data[1:0] : 2'b00;
        set = '0;
        set[IRQ_VBLANK] = vblank_hit & ~vblank_prev;
        set[IRQ_FILL] = state == ST_DONE;
        busy = state != ST_IDLE;
        state_next = state == ST_FILL ? (fill_cnt == 14'd1 ? ST_DONE : ST_FILL) :
                     state == ST_DONE ? ST_IDLE :
                     (wr && acc_addr == REG_FILL_GO) ? (fill_cnt == '0 ? ST_DONE : ST_FILL) : ST_IDLE;
    end

    always_ff @(posedge CLK100MHz) begin
        if (rst) state <= ST_IDLE;
        else state <= state_next;
    end

    always_ff @(posedge CLK100MHz) begin
        if (rst) begin
            acc_valid   <= 1'b0;
            acc_addr    <= '0;
            acc_data    <= '0;
            acc_rw      <= 1'b0;
            vblank_prev <= 1'b0;
            addr_reg    <= '0;
            incr        <= 8'd1;
            irq_en      <= '0;
            pending     <= '0;
            fill_val    <= '0;
            fill_cnt    <= '0;
            vram_we     <= 1'b0;
            vram_addr   <= '0;
            vram_wdata  <= '0;
            irq         <= 1'b0;
        end else begin
            acc_valid <= strobe;
            if (strobe) begin
                acc_addr <= addr;
                acc_data <= data;
                acc_rw   <= rw;
            end
            vblank_prev <= vblank_hit;
            pending <= (pending & ~ack) | set;
            irq <= |(pending & irq_en);
            vram_we <= 1'b0;
            if (wr && acc_addr == REG_IRQ_EN) irq_en <= acc_data[1:0];
            if (state == ST_FILL) begin
                vram_we    <= 1'b1;
                vram_addr  <= addr_reg;
                vram_wdata <= fill_val;
                addr_reg   <= addr_step;
                fill_cnt   <= fill_cnt - 14'd1;
            end else if (wr && !busy) begin
                case (acc_addr)
                    REG_ADDR_LO:     addr_reg[7:0] <= acc_data;
                    REG_ADDR_HI:     addr_reg <= ADDR_WIDTH'({acc_data, addr_reg[7:0]});
                    REG_DATA: begin
                        vram_we    <= 1'b1;
                        vram_addr  <= addr_reg;
                        vram_wdata <= acc_data;
                        addr_reg   <= addr_step;
                    end
                    REG_INCR:        incr <= acc_data;
                    REG_FILL_VAL:    fill_val <= acc_data;
                    REG_FILL_CNT_LO: fill_cnt[7:0] <= acc_data;
                    REG_FILL_CNT_HI: fill_cnt[13:8] <= acc_data[5:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gpu_bus_interface.sv
// tb_gpu_bus_interface: randomized and directed bus traffic checked against a cycle-stamped transaction model
module tb_gpu_bus_interface;
    localparam int S  = 2;
    localparam int AW = 13;

    logic clk = 1'b0, rst = 1'b1, rw = 1'b0, cs = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] addr = '0;
    logic [8:0] scanline = '0;
    logic vram_we, busy, irq;
    logic [AW-1:0] vram_addr;
    logic [7:0] vram_wdata;

    typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} wr_t;
    typedef struct {int cyc; logic [AW-1:0] a; logic [7:0] d;} obs_t;
    wr_t exp_wr[int];
    bit busy_at[int];
    obs_t obs[$];
    int cyc = 0, checks = 0, errors = 0, busy_seen = 0, fd = -1, last_end = 0;
    logic [AW-1:0] maddr;
    logic [7:0] mincr, mfv;
    logic [13:0] mcnt;
    logic [1:0] men, mpend;

    gpu_bus_interface #(.ADDR_WIDTH(AW), .VBLANK_LINE(480), .SYNC_STAGES(S)) dut (
        .CLK100MHz(clk), .rst(rst), .data(data), .addr(addr), .rw(rw), .cs_clock(cs),
        .scanline(scanline), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    // Every cycle: the write port and busy must match the cycle-stamped expectations exactly
    always @(negedge clk) if (cyc > 0) begin
        chk("vram_we", vram_we, exp_wr.exists(cyc));
        if (exp_wr.exists(cyc)) begin
            chk("vram_addr", vram_addr, exp_wr[cyc].a);
            chk("vram_wdata", vram_wdata, exp_wr[cyc].d);
        end
        chk("busy", busy, busy_at.exists(cyc));
        if (vram_we) obs.push_back('{cyc, vram_addr, vram_wdata});
        if (busy) busy_seen++;
    end

    task automatic model_reset();
        maddr = '0; mincr = 8'd1; mfv = '0; mcnt = '0; men = '0; mpend = '0; fd = -1;
    endtask

    task automatic apply_model(input logic [3:0] a, input logic [7:0] d, input logic r, input int p);
        bit bz;
        if (fd >= 0 && fd < p) begin mpend[1] = 1'b1; fd = -1; end
        bz = busy_at.exists(p - 1);
        if (!r) begin
            if (a == 4) men = d[1:0];
            else if (a == 5) mpend &= ~d[1:0];
            else if (!bz) case (a)
                0: maddr[7:0] = d;
                1: maddr[12:8] = d[4:0];
                2: begin exp_wr[p] = '{maddr, d}; maddr += AW'(mincr); end
                3: mincr = d;
                6: mfv = d;
                7: mcnt[7:0] = d;
                8: mcnt[13:8] = d[5:0];
                9: begin
                    for (int k = 0; k <= int'(mcnt); k++) busy_at[p + k] = 1'b1;
                    for (int k = 1; k <= int'(mcnt); k++) begin
                        exp_wr[p + k] = '{maddr, mfv};
                        maddr += AW'(mincr);
                    end
                    fd = p + int'(mcnt) + 1;
                    last_end = fd;
                    mcnt = '0;
                end
                default: ;
            endcase
        end
        if (fd == p) begin mpend[1] = 1'b1; fd = -1; end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d, input logic r = 1'b0, input int hold = S + 3);
        addr = a; data = d; rw = r; cs = 1'b1;
        apply_model(a, d, r, cyc + S + 2);
        repeat (hold) @(negedge clk);
        cs = 1'b0;
        repeat (S + 3) @(negedge clk);
    endtask

    task automatic check_irq();
        if (fd >= 0 && fd < cyc) begin mpend[1] = 1'b1; fd = -1; end
        if (fd < 0) chk("irq_model", irq, |(mpend & men));
    endtask

    task automatic set_scan(input logic [8:0] v);
        if (v == 9'd480 && scanline != 9'd480) mpend[0] = 1'b1;
        scanline = v;
    endtask

    task automatic wait_idle();
        while (cyc <= last_end + 2) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = cyc + 1; k <= cyc + 20000; k++) begin
            exp_wr.delete(k);
            busy_at.delete(k);
        end
        model_reset();
        @(negedge clk);
        chk("reset_we_next", vram_we, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        logic [3:0] ra;
        logic [7:0] rd;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", vram_we, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_wdata", vram_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_irq", irq, 0);

        obs.delete();
        bus_write(4'd0, 8'hFE); bus_write(4'd1, 8'h1F); bus_write(4'd3, 8'd1);
        bus_write(4'd2, 8'hAA); bus_write(4'd2, 8'hBB); bus_write(4'd2, 8'hCC);
        chk("stream_n", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("stream0_a", obs[0].a, 13'h1FFE); chk("stream0_d", obs[0].d, 8'hAA);
            chk("stream1_a", obs[1].a, 13'h1FFF); chk("stream1_d", obs[1].d, 8'hBB);
            chk("stream_wrap", obs[2].a, 13'h0000);
        end

        obs.delete();
        t0 = cyc;
        bus_write(4'd2, 8'h11, 1'b0, 20);
        chk("lat_n", obs.size(), 1);
        if (obs.size() == 1) chk("lat_cyc", obs[0].cyc - t0, S + 2);

        bus_write(4'd0, 8'h00); bus_write(4'd1, 8'h01); bus_write(4'd3, 8'd2);
        bus_write(4'd6, 8'h55); bus_write(4'd7, 8'd4); bus_write(4'd8, 8'd0); bus_write(4'd4, 8'd2);
        obs.delete();
        busy_seen = 0;
        bus_write(4'd9, 8'h00);
        wait_idle();
        chk("fill_n", obs.size(), 4);
        if (obs.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("fill_a", obs[i].a, 13'h100 + 13'(2 * i));
                chk("fill_d", obs[i].d, 8'h55);
            end
            chk("fill_consec", obs[3].cyc - obs[0].cyc, 3);
        end
        chk("fill_busy_len", busy_seen, 5);
        chk("fill_irq", irq, 1);
        check_irq();
        bus_write(4'd5, 8'd2);
        chk("fill_ack", irq, 0);
        check_irq();

        obs.delete();
        bus_write(4'd9, 8'h00);
        wait_idle();
        chk("zero_fill_n", obs.size(), 0);
        chk("zero_fill_irq", irq, 1);
        bus_write(4'd5, 8'd2);
        check_irq();

        bus_write(4'd7, 8'd100);
        obs.delete();
        bus_write(4'd9, 8'h00);
        bus_write(4'd2, 8'h77);
        wait_idle();
        chk("busy_drop_n", obs.size(), 100);
        check_irq();
        bus_write(4'd5, 8'd3);

        bus_write(4'd4, 8'd1);
        set_scan(9'd479);
        repeat (3) @(negedge clk);
        set_scan(9'd480);
        repeat (10) @(negedge clk);
        chk("vbl_irq", irq, 1);
        check_irq();
        bus_write(4'd5, 8'd1);
        repeat (5) @(negedge clk);
        chk("vbl_once", irq, 0);
        check_irq();
        set_scan(9'd0);
        repeat (3) @(negedge clk);
        set_scan(9'd480);
        repeat (4) @(negedge clk);
        chk("vbl_reentry", irq, 1);
        set_scan(9'd0);
        bus_write(4'd5, 8'd1);
        check_irq();

        bus_write(4'd4, 8'd2); bus_write(4'd7, 8'd100); bus_write(4'd9, 8'h00);
        repeat (20) @(negedge clk);
        do_reset();
        chk("rst2_we", vram_we, 0);
        chk("rst2_busy", busy, 0);
        chk("rst2_addr", vram_addr, 0);
        chk("rst2_wdata", vram_wdata, 0);
        chk("rst2_irq", irq, 0);
        obs.delete();
        bus_write(4'd0, 8'd5); bus_write(4'd2, 8'h01); bus_write(4'd2, 8'h02);
        chk("rst_incr_n", obs.size(), 2);
        if (obs.size() == 2) chk("rst_incr_a", obs[1].a, 13'h0006);

        repeat (200) begin
            ra = 4'($urandom_range(0, 15));
            rd = 8'($urandom);
            if (ra == 4'd8) rd &= 8'h01;
            bus_write(ra, rd, $urandom_range(0, 7) == 0, S + 2 + $urandom_range(1, 4));
            check_irq();
        end
        wait_idle();
        check_irq();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
